// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/response bundle for alu_pipe.
//   Request : i_valid / o_ready handshake carrying i_A, i_B, i_Control, i_Tag.
//   Response: o_valid / i_ready handshake carrying o_Result, o_Flag, o_Tag.
//   Status  : o_busy (multiply in flight or waiting to write its result).
// Signal names keep the ALU's point of view: i_* are driven by the master
// (requester/consumer side), o_* are driven by the ALU (slave).
interface alu_pipe_if #(
  parameter int D_WIDTH = 32,
  parameter int TAG_W   = 4
);
  logic               i_valid;
  logic               o_ready;
  logic [D_WIDTH-1:0] i_A;
  logic [D_WIDTH-1:0] i_B;
  logic [3:0]         i_Control;
  logic [TAG_W-1:0]   i_Tag;
  logic               o_valid;
  logic               i_ready;
  logic [D_WIDTH-1:0] o_Result;
  logic [3:0]         o_Flag;
  logic [TAG_W-1:0]   o_Tag;
  logic               o_busy;

  modport master (
    output i_valid, i_A, i_B, i_Control, i_Tag, i_ready,
    input  o_ready, o_valid, o_Result, o_Flag, o_Tag, o_busy
  );

  modport slave (
    input  i_valid, i_A, i_B, i_Control, i_Tag, i_ready,
    output o_ready, o_valid, o_Result, o_Flag, o_Tag, o_busy
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered, handshaked integer ALU for the execute stage.
//   Single-cycle ops (ADD SUB MOVB MOVA AND OR XOR SHL SHR ASR) produce a
//   registered result one edge after acceptance. MUL (code 10) runs an
//   iterative shift-add multiplier, one multiplier bit per cycle, and
//   delivers the low D_WIDTH product bits D_WIDTH edges after acceptance.
//   Codes 11-15 (and 10 when MUL_EN=0) behave as MOVA.
// Ports:
//   i_clk    clock, all state on rising edge
//   i_rst_n  asynchronous active-low reset, synchronous release
//   io_alu   alu_pipe_if.slave: request (i_valid/o_ready, i_A, i_B,
//            i_Control, i_Tag), response (o_valid/i_ready, o_Result,
//            o_Flag={N,Z,C,V}, o_Tag) and o_busy.
module alu_pipe #(
  parameter int D_WIDTH = 32,
  parameter int TAG_W   = 4,
  parameter bit MUL_EN  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  alu_pipe_if.slave  io_alu
);

  localparam int SH_W  = $clog2(D_WIDTH);
  localparam int CNT_W = SH_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Multiplier working registers
  logic [CNT_W-1:0]   r_cnt;
  logic [D_WIDTH-1:0] r_ma;
  logic [D_WIDTH-1:0] r_mb;
  logic [D_WIDTH-1:0] r_pp;
  logic [TAG_W-1:0]   r_mtag;

  // Output register
  logic               r_valid;
  logic [D_WIDTH-1:0] r_result;
  logic [3:0]         r_flag;
  logic [TAG_W-1:0]   r_tag;

  logic               w_out_free;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_last;
  logic               w_load_alu;
  logic               w_load_mul;
  logic               w_ready;
  logic               w_busy;
  logic [D_WIDTH-1:0] w_pp_nxt;
  logic [D_WIDTH-1:0] w_mul_res;

  logic [SH_W-1:0]    w_amt;
  logic [D_WIDTH:0]   w_add;
  logic [D_WIDTH:0]   w_sub;
  logic [D_WIDTH:0]   w_shl;
  logic [D_WIDTH:0]   w_shr;
  logic signed [D_WIDTH:0] w_asr;
  logic [D_WIDTH-1:0] w_res;
  logic               w_c;
  logic               w_v;

  function automatic logic [3:0] mk_flags(input logic [D_WIDTH-1:0] res,
                                          input logic c, input logic v);
    return {res[D_WIDTH-1], (res == '0), c, v};
  endfunction

  // ---- Stage 0: single-cycle datapath (combinational) ----
  // Shifts are done one bit wider so the last bit shifted out lands in the
  // extra position and becomes the carry flag (zero when the amount is 0).
  assign w_amt = io_alu.i_B[SH_W-1:0];
  assign w_add = {1'b0, io_alu.i_A} + {1'b0, io_alu.i_B};
  assign w_sub = {1'b0, io_alu.i_A} - {1'b0, io_alu.i_B};
  assign w_shl = {1'b0, io_alu.i_A} << w_amt;
  assign w_shr = {io_alu.i_A, 1'b0} >> w_amt;
  assign w_asr = $signed({io_alu.i_A, 1'b0}) >>> w_amt;

  always_comb begin
    w_res = io_alu.i_A;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (io_alu.i_Control)
      4'd0: begin
        w_res = w_add[D_WIDTH-1:0];
        w_c   = w_add[D_WIDTH];
        w_v   = (io_alu.i_A[D_WIDTH-1] == io_alu.i_B[D_WIDTH-1]) &&
                (w_add[D_WIDTH-1] != io_alu.i_A[D_WIDTH-1]);
      end
      4'd1: begin
        w_res = w_sub[D_WIDTH-1:0];
        // Top bit of the widened difference is the borrow.
        w_c   = ~w_sub[D_WIDTH];
        w_v   = (io_alu.i_A[D_WIDTH-1] != io_alu.i_B[D_WIDTH-1]) &&
                (w_sub[D_WIDTH-1] != io_alu.i_A[D_WIDTH-1]);
      end
      4'd2: w_res = io_alu.i_B;
      4'd4: w_res = io_alu.i_A & io_alu.i_B;
      4'd5: w_res = io_alu.i_A | io_alu.i_B;
      4'd6: w_res = io_alu.i_A ^ io_alu.i_B;
      4'd7: begin
        w_res = w_shl[D_WIDTH-1:0];
        w_c   = w_shl[D_WIDTH];
      end
      4'd8: begin
        w_res = w_shr[D_WIDTH:1];
        w_c   = w_shr[0];
      end
      4'd9: begin
        w_res = w_asr[D_WIDTH:1];
        w_c   = w_asr[0];
      end
      default: w_res = io_alu.i_A;
    endcase
  end

  assign w_is_mul   = MUL_EN && (io_alu.i_Control == 4'd10);
  assign w_out_free = !r_valid || io_alu.i_ready;
  assign w_accept   = io_alu.i_valid && w_ready;
  assign w_load_alu = w_accept && !w_is_mul;
  assign w_mul_last = (r_cnt == CNT_W'(D_WIDTH - 1));

  // Shift-add step: add the shifted multiplicand when the current LSB is set.
  assign w_pp_nxt  = r_pp + (r_mb[0] ? r_ma : '0);
  // In MUL the final step's sum is loaded directly; in HOLD it is already in r_pp.
  assign w_mul_res = (r_state == S_HOLD) ? r_pp : w_pp_nxt;

  // ---- FSM: state register ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:  if (w_mul_last) w_state_nxt = w_out_free ? S_IDLE : S_HOLD;
      S_HOLD: if (w_out_free) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    w_ready    = 1'b0;
    w_busy     = 1'b1;
    w_load_mul = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = w_out_free;
        w_busy  = 1'b0;
      end
      S_MUL:  w_load_mul = w_mul_last && w_out_free;
      S_HOLD: w_load_mul = w_out_free;
      default: w_busy = 1'b0;
    endcase
  end

  // ---- Multiplier iteration registers ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_ma   <= '0;
      r_mb   <= '0;
      r_pp   <= '0;
      r_mtag <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt  <= '0;
      r_ma   <= io_alu.i_A;
      r_mb   <= io_alu.i_B;
      r_pp   <= '0;
      r_mtag <= io_alu.i_Tag;
    end else if (r_state == S_MUL) begin
      // Counter wraps back to 0 after the final iteration.
      r_cnt  <= r_cnt + CNT_W'(1);
      r_ma   <= r_ma << 1;
      r_mb   <= r_mb >> 1;
      r_pp   <= w_pp_nxt;
    end
  end

  // ---- Stage 1: output register (writeback side) ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_flag   <= '0;
      r_tag    <= '0;
    end else if (w_load_alu) begin
      r_valid  <= 1'b1;
      r_result <= w_res;
      r_flag   <= mk_flags(w_res, w_c, w_v);
      r_tag    <= io_alu.i_Tag;
    end else if (w_load_mul) begin
      r_valid  <= 1'b1;
      r_result <= w_mul_res;
      r_flag   <= mk_flags(w_mul_res, 1'b0, 1'b0);
      r_tag    <= r_mtag;
    end else if (io_alu.i_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign io_alu.o_ready  = w_ready;
  assign io_alu.o_busy   = w_busy;
  assign io_alu.o_valid  = r_valid;
  assign io_alu.o_Result = r_result;
  assign io_alu.o_Flag   = r_flag;
  assign io_alu.o_Tag    = r_tag;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam int DW = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.D_WIDTH(DW), .TAG_W(TW)) bus ();

  alu_pipe #(.D_WIDTH(DW), .TAG_W(TW), .MUL_EN(1'b1)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_alu  (bus)
  );

  typedef struct packed {
    logic [DW-1:0] res;
    logic [3:0]    flag;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, exp, $time);
  endtask

  // Reference model: plain wide arithmetic straight from the op definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [TW-1:0] tag);
    exp_t e;
    longint unsigned u;
    longint sa, sb, s;
    int amt;
    logic [DW-1:0] r;
    logic c, v;
    amt = int'(b[4:0]);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r = a; c = 1'b0; v = 1'b0; u = 0; s = 0;
    case (op)
      4'd0: begin
        u = longint'({32'b0, a}) + longint'({32'b0, b});
        r = u[31:0]; c = u[32];
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: r = b;
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: begin
        u = longint'({32'b0, a}) << amt;
        r = u[31:0]; c = u[32];
      end
      4'd8: begin
        r = a >> amt; c = (amt != 0) ? a[amt-1] : 1'b0;
      end
      4'd9: begin
        r = $signed(a) >>> amt; c = (amt != 0) ? a[amt-1] : 1'b0;
      end
      4'd10: begin
        u = {32'b0, a} * {32'b0, b};
        r = u[31:0];
      end
      default: r = a;
    endcase
    e.res  = r;
    e.flag = {r[31], (r == 0), c, v};
    e.tag  = tag;
    return e;
  endfunction

  // Scoreboard monitor, sampled on the falling edge (inputs and outputs stable).
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus.i_valid && bus.o_ready)
        q.push_back(model(bus.i_Control, bus.i_A, bus.i_B, bus.i_Tag));
      if (bus.o_valid) begin
        if (q.size() == 0) chk("unexpected_valid", 64'(bus.o_valid), 64'd0);
        else begin
          chk("sb_result", 64'(bus.o_Result), 64'(q[0].res));
          chk("sb_flag",   64'(bus.o_Flag),   64'(q[0].flag));
          chk("sb_tag",    64'(bus.o_Tag),    64'(q[0].tag));
          if (bus.i_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic [3:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [TW-1:0] tag);
    int n;
    n = 0;
    bus.i_valid = 1'b1; bus.i_Control = op; bus.i_A = a; bus.i_B = b; bus.i_Tag = tag;
    while (!bus.o_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("accept_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic exp_out(input string name, input logic [DW-1:0] res,
                         input logic [3:0] flag, input logic [TW-1:0] tag);
    chk({name, "_valid"}, 64'(bus.o_valid), 64'd1);
    chk({name, "_res"},   64'(bus.o_Result), 64'(res));
    chk({name, "_flag"},  64'(bus.o_Flag), 64'(flag));
    chk({name, "_tag"},   64'(bus.o_Tag), 64'(tag));
  endtask

  function automatic logic [DW-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n, busy_cnt, ready_seen;
    logic [3:0] op;
    bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_A = '0; bus.i_B = '0;
    bus.i_Control = '0; bus.i_Tag = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",  64'(bus.o_valid), 64'd0);
    chk("rst_result", 64'(bus.o_Result), 64'd0);
    chk("rst_flag",   64'(bus.o_Flag), 64'd0);
    chk("rst_tag",    64'(bus.o_Tag), 64'd0);
    chk("rst_busy",   64'(bus.o_busy), 64'd0);
    chk("rst_ready",  64'(bus.o_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Directed cases, consumer always ready
    drive_req(4'd0, 32'h7FFF_FFFF, 32'h1, 4'd1);
    exp_out("add_ovf", 32'h8000_0000, 4'b1001, 4'd1);
    drive_req(4'd1, 32'd5, 32'd5, 4'd2);
    exp_out("sub_eq", 32'h0, 4'b0110, 4'd2);
    drive_req(4'd1, 32'd3, 32'd5, 4'd3);
    exp_out("sub_neg", 32'hFFFF_FFFE, 4'b1000, 4'd3);
    drive_req(4'd7, 32'h8000_0001, 32'd1, 4'd4);
    exp_out("shl1", 32'h0000_0002, 4'b0010, 4'd4);
    drive_req(4'd9, 32'h8000_0000, 32'd31, 4'd5);
    exp_out("asr31", 32'hFFFF_FFFF, 4'b1000, 4'd5);
    drive_req(4'd7, 32'h0000_0005, 32'd0, 4'd6);
    exp_out("shl0", 32'h0000_0005, 4'b0000, 4'd6);

    // Multiply latency, busy and ready behaviour
    drive_req(4'd10, 32'h0001_0000, 32'h0001_0001, 4'd9);
    n = 0; busy_cnt = 0; ready_seen = 0;
    while (!bus.o_valid && n < 100) begin
      if (bus.o_busy) busy_cnt++;
      if (bus.o_ready) ready_seen++;
      @(posedge clk); #1; n++;
    end
    chk("mul_latency", 64'(n), 64'd32);
    chk("mul_busy_cycles", 64'(busy_cnt), 64'd32);
    chk("mul_ready_during", 64'(ready_seen), 64'd0);
    exp_out("mul", 32'h0001_0000, 4'b0000, 4'd9);
    chk("mul_busy_after", 64'(bus.o_busy), 64'd0);

    // Back-to-back ADDs at full rate
    for (int i = 0; i < 40; i++) begin
      bus.i_valid = 1'b1; bus.i_Control = 4'd0; bus.i_A = $urandom(); bus.i_B = $urandom();
      bus.i_Tag = TW'(i); bus.i_ready = 1'b1;
      if (i == 20) chk("full_rate_ready", 64'(bus.o_ready), 64'd1);
      @(posedge clk); #1;
    end

    // Back-to-back ADDs with consumer toggling
    for (int i = 0; i < 100; i++) begin
      bus.i_valid = 1'b1; bus.i_Control = 4'd0; bus.i_A = rnd_opnd(); bus.i_B = rnd_opnd();
      bus.i_Tag = TW'(i); bus.i_ready = i[0];
      @(posedge clk); #1;
    end

    // Randomized mix of all opcodes with random backpressure
    for (int i = 0; i < 1500; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd10 && $urandom_range(0, 3) != 0) op = 4'd1;
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.i_Control = op; bus.i_A = rnd_opnd(); bus.i_B = rnd_opnd();
      bus.i_Tag = TW'($urandom());
      bus.i_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end

    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || bus.o_busy) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);

    // Reset in the middle of a multiply
    drive_req(4'd10, 32'h1234_5678, 32'h0000_0003, 4'd7);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_mul_busy", 64'(bus.o_busy), 64'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(bus.o_valid), 64'd0);
    chk("abort_busy",  64'(bus.o_busy), 64'd0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_output", 64'(bus.o_valid), 64'd0);
    mon_en = 1'b1;
    drive_req(4'd0, 32'd2, 32'd3, 4'd11);
    exp_out("post_rst_add", 32'd5, 4'b0000, 4'd11);
    drive_req(4'd10, 32'd7, 32'd6, 4'd12);
    n = 0;
    while (!bus.o_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    exp_out("post_rst_mul", 32'd42, 4'b0000, 4'd12);
    @(posedge clk); #1;
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
